// File: rtl/flit_sink_monitor_if.sv
// Flit handshake bundle between a flit source and flit_sink_monitor.
interface flit_sink_monitor_if #(
   parameter int FLIT_W = 54
);
   logic              flit_valid;
   logic [FLIT_W-1:0] flit_data;
   logic              flit_ready;

   modport master (output flit_valid, output flit_data, input flit_ready);
   modport slave  (input flit_valid, input flit_data, output flit_ready);
endinterface

// File: rtl/flit_sink_monitor.sv
// Packet sink: delimits flit packets, reports length and bit-toggle activity.
// Optional FLIT_HALF_TOGGLE_EN adds per-half toggle reports.
module flit_sink_monitor #(
   parameter int FLIT_W  = 54,
   parameter int PAYLOAD = 20,
   parameter int MAX_LEN = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   flit_sink_monitor_if.slave   flit,
   output logic                 pkt_done,
   output logic [7:0]           pkt_len,
   output logic [15:0]          pkt_toggles,
   output logic                 len_err,
   output logic [15:0]          pkt_count,
`ifdef FLIT_HALF_TOGGLE_EN
   output logic [15:0]          pkt_toggles_lo,
   output logic [15:0]          pkt_toggles_hi,
`endif
   output logic [31:0]          total_toggles
);
   localparam int unsigned FW   = FLIT_W;
   localparam int unsigned LO_W = FLIT_W / 2;

   typedef enum logic [1:0] {IDLE, RECV, REPORT} state_t;

   state_t            state_q, state_d;
   logic [7:0]        len_q, len_d;
   logic [15:0]       acc_q, acc_d;
   logic [FLIT_W-1:0] prev_q;
   logic [7:0]        pkt_len_q;
   logic [15:0]       pkt_tog_q;
   logic              len_err_q;
   logic [15:0]       count_q;
   logic [31:0]       total_q;
   logic [FLIT_W-1:0] diff;
   logic [15:0]       tog, tog_lo, tog_hi;
   logic [32:0]       tot_sum;
   logic              accept, report_entry;
`ifdef FLIT_HALF_TOGGLE_EN
   logic [15:0]       acc_lo_q, acc_lo_d, acc_hi_q, acc_hi_d;
   logic [15:0]       pkt_lo_q, pkt_hi_q;
`endif

   assign flit.flit_ready = (state_q != REPORT);
   assign accept          = flit.flit_valid && flit.flit_ready;

   always_comb begin
      tog_lo = '0;
      tog_hi = '0;
      diff   = flit.flit_data ^ prev_q;
      for (int unsigned i = 0; i < FW; i++) begin
         if (i < LO_W) tog_lo = tog_lo + 16'(diff[i]);
         else          tog_hi = tog_hi + 16'(diff[i]);
      end
      tog = tog_lo + tog_hi;
   end

   // len_d/acc_d always hold the packet totals as of the edge, so the report
   // registers load from them on either REPORT entry path.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      acc_d   = acc_q;
`ifdef FLIT_HALF_TOGGLE_EN
      acc_lo_d = acc_lo_q;
      acc_hi_d = acc_hi_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               len_d   = 8'd1;
               acc_d   = tog;
`ifdef FLIT_HALF_TOGGLE_EN
               acc_lo_d = tog_lo;
               acc_hi_d = tog_hi;
`endif
               state_d = (len_d == 8'(MAX_LEN)) ? REPORT : RECV;
            end
         end
         RECV: begin
            if (!flit.flit_valid) begin
               state_d = REPORT;
            end else begin
               len_d = len_q + 8'd1;
               acc_d = acc_q + tog;
`ifdef FLIT_HALF_TOGGLE_EN
               acc_lo_d = acc_lo_q + tog_lo;
               acc_hi_d = acc_hi_q + tog_hi;
`endif
               if (len_d == 8'(MAX_LEN)) state_d = REPORT;
            end
         end
         REPORT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign report_entry = (state_d == REPORT) && (state_q != REPORT);
   assign tot_sum      = {1'b0, total_q} + {17'b0, pkt_tog_q};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         len_q     <= '0;
         acc_q     <= '0;
         prev_q    <= '0;
         pkt_len_q <= '0;
         pkt_tog_q <= '0;
         len_err_q <= 1'b0;
         count_q   <= '0;
         total_q   <= '0;
`ifdef FLIT_HALF_TOGGLE_EN
         acc_lo_q  <= '0;
         acc_hi_q  <= '0;
         pkt_lo_q  <= '0;
         pkt_hi_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         acc_q   <= acc_d;
`ifdef FLIT_HALF_TOGGLE_EN
         acc_lo_q <= acc_lo_d;
         acc_hi_q <= acc_hi_d;
`endif
         if (accept) prev_q <= flit.flit_data;
         if (report_entry) begin
            pkt_len_q <= len_d;
            pkt_tog_q <= acc_d;
            len_err_q <= (len_d != 8'(PAYLOAD));
`ifdef FLIT_HALF_TOGGLE_EN
            pkt_lo_q  <= acc_lo_d;
            pkt_hi_q  <= acc_hi_d;
`endif
         end
         if (state_q == REPORT) begin
            count_q <= count_q + 16'd1;
            total_q <= tot_sum[32] ? '1 : tot_sum[31:0];
         end
      end
   end

   assign pkt_done      = (state_q == REPORT);
   assign pkt_len       = pkt_len_q;
   assign pkt_toggles   = pkt_tog_q;
   assign len_err       = len_err_q;
   assign pkt_count     = count_q;
   assign total_toggles = total_q;
`ifdef FLIT_HALF_TOGGLE_EN
   assign pkt_toggles_lo = pkt_lo_q;
   assign pkt_toggles_hi = pkt_hi_q;
`endif
endmodule

// File: tb/tb_flit_sink_monitor.sv
// Scoreboard bench for flit_sink_monitor: bursts are split into packets by a
// queue-level model; a negedge monitor pops and compares each report.
module tb_flit_sink_monitor;
   localparam int FLIT_W  = 54;
   localparam int PAYLOAD = 20;
   localparam int MAX_LEN = 255;
   localparam int LO_W    = FLIT_W / 2;
   localparam logic [FLIT_W-1:0] ALL1 = '1;

   typedef struct {
      int len;
      int tog;
      int lo;
      int hi;
      bit err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pkt_done, len_err;
   logic [7:0]  pkt_len;
   logic [15:0] pkt_toggles, pkt_count;
   logic [31:0] total_toggles;
`ifdef FLIT_HALF_TOGGLE_EN
   logic [15:0] pkt_toggles_lo, pkt_toggles_hi;
`endif

   flit_sink_monitor_if #(.FLIT_W(FLIT_W)) fif ();

   flit_sink_monitor #(.FLIT_W(FLIT_W), .PAYLOAD(PAYLOAD), .MAX_LEN(MAX_LEN)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flit          (fif),
      .pkt_done      (pkt_done),
      .pkt_len       (pkt_len),
      .pkt_toggles   (pkt_toggles),
      .len_err       (len_err),
      .pkt_count     (pkt_count),
`ifdef FLIT_HALF_TOGGLE_EN
      .pkt_toggles_lo(pkt_toggles_lo),
      .pkt_toggles_hi(pkt_toggles_hi),
`endif
      .total_toggles (total_toggles)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   exp_t sb[$];
   logic [FLIT_W-1:0] burst_q[$];
   logic [FLIT_W-1:0] m_prev = '0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic logic [FLIT_W-1:0] rnd_flit();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[FLIT_W-1:0];
   endfunction

   // Model: every MAX_LEN accepted flits close a packet; the rest closes on the gap.
   task automatic model_burst();
      exp_t e;
      logic [FLIT_W-1:0] x;
      e = '{len: 0, tog: 0, lo: 0, hi: 0, err: 0};
      foreach (burst_q[i]) begin
         x = burst_q[i] ^ m_prev;
         e.lo  += $countones(x[LO_W-1:0]);
         e.hi  += $countones(x[FLIT_W-1:LO_W]);
         e.tog += $countones(x);
         e.len++;
         m_prev = burst_q[i];
         if (e.len == MAX_LEN) begin
            e.err = (e.len != PAYLOAD);
            sb.push_back(e);
            e = '{len: 0, tog: 0, lo: 0, hi: 0, err: 0};
         end
      end
      if (e.len > 0) begin
         e.err = (e.len != PAYLOAD);
         sb.push_back(e);
      end
   endtask

   // Drive burst_q back-to-back, holding a flit while ready is low; called at negedge.
   task automatic drive_flits();
      int stall;
      foreach (burst_q[i]) begin
         fif.flit_valid = 1'b1;
         fif.flit_data  = burst_q[i];
         stall = 0;
         while (!fif.flit_ready) begin
            @(negedge clk);
            stall++;
            if (stall > 4) begin
               $display("FAIL ready_stall: got %0d stall cycles expected at most 1", stall);
               break;
            end
         end
         @(negedge clk);
      end
      fif.flit_valid = 1'b0;
   endtask

   task automatic run_burst(input int gap);
      model_burst();
      drive_flits();
      repeat (gap) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      fif.flit_valid = 1'b1;
      fif.flit_data  = rnd_flit();
      @(negedge clk);
      check("rst_ready", fif.flit_ready, 1);
      check("rst_done", pkt_done, 0);
      check("rst_len", pkt_len, 0);
      check("rst_tog", pkt_toggles, 0);
      check("rst_err", len_err, 0);
      check("rst_count", pkt_count, 0);
      check("rst_total", total_toggles, 0);
      @(negedge clk);
      fif.flit_valid = 1'b0;
      rst_n  = 1'b1;
      m_prev = '0;
      check("sb_empty_at_reset", sb.size(), 0);
      sb.delete();
   endtask

   // Monitor: pops on pkt_done, checks hold of report outputs otherwise.
   initial begin : monitor
      exp_t e;
      exp_t last;
      int   exp_count;
      longint exp_total;
      bit   cnt_pending;
      last = '{len: 0, tog: 0, lo: 0, hi: 0, err: 0};
      exp_count = 0;
      exp_total = 0;
      cnt_pending = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            last = '{len: 0, tog: 0, lo: 0, hi: 0, err: 0};
            exp_count = 0;
            exp_total = 0;
            cnt_pending = 0;
         end else begin
            if (cnt_pending) begin
               check("pkt_count", pkt_count, exp_count);
               check("total_toggles", total_toggles, exp_total);
               cnt_pending = 0;
            end
            if (pkt_done) begin
               check("ready_in_report", fif.flit_ready, 0);
               if (sb.size() == 0) begin
                  check("unexpected_pkt_done", 1, 0);
               end else begin
                  e = sb.pop_front();
                  check("pkt_len", pkt_len, e.len);
                  check("pkt_toggles", pkt_toggles, e.tog);
                  check("len_err", len_err, e.err);
`ifdef FLIT_HALF_TOGGLE_EN
                  check("pkt_toggles_lo", pkt_toggles_lo, e.lo);
                  check("pkt_toggles_hi", pkt_toggles_hi, e.hi);
`endif
                  last = e;
                  exp_count++;
                  exp_total += e.tog;
                  cnt_pending = 1;
               end
            end else begin
               check("hold_len", pkt_len, last.len);
               check("hold_tog", pkt_toggles, last.tog);
               check("hold_err", len_err, last.err);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      fif.flit_valid = 1'b0;
      fif.flit_data  = '0;
      @(negedge clk);

      // Three flits 0 / all-ones / 0 -> 108 toggles, short packet
      do_reset();
      burst_q = '{'0, ALL1, '0};
      run_burst(3);

      // Twenty alternating 1/0 flits -> well-formed packet, 20 toggles
      do_reset();
      burst_q.delete();
      for (int i = 0; i < 20; i++) burst_q.push_back((i % 2 == 0) ? FLIT_W'(1) : '0);
      run_burst(7);

      // Half split: 0 then all-ones
      do_reset();
      burst_q = '{'0, ALL1};
      run_burst(2);

      // Next burst offered during REPORT must be held, not lost
      burst_q.delete();
      repeat (5) burst_q.push_back(rnd_flit());
      run_burst(1);
      burst_q.delete();
      repeat (4) burst_q.push_back(rnd_flit());
      run_burst(1);
      burst_q.delete();
      repeat (PAYLOAD) burst_q.push_back(rnd_flit());
      run_burst(2);

      // 300 consecutive valid cycles -> truncated 255 then 45
      burst_q.delete();
      repeat (300) burst_q.push_back(rnd_flit());
      run_burst(3);

      // Random bursts and gaps
      for (int b = 0; b < 40; b++) begin
         int n;
         n = ($urandom_range(0, 3) == 0) ? PAYLOAD : int'($urandom_range(1, 30));
         burst_q.delete();
         for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 5))
               0:       burst_q.push_back('0);
               1:       burst_q.push_back(ALL1);
               default: burst_q.push_back(rnd_flit());
            endcase
         end
         run_burst(int'($urandom_range(1, 4)));
      end
      repeat (3) @(negedge clk);
      check("sb_drained", sb.size(), 0);

      // Reset at flit 10 discards the partial packet; fresh packet starts from prev 0
      burst_q.delete();
      repeat (10) burst_q.push_back(rnd_flit());
      drive_flits();
      do_reset();
      burst_q.delete();
      repeat (PAYLOAD) burst_q.push_back(rnd_flit());
      run_burst(5);
      check("count_after_mid_reset", pkt_count, 1);

      repeat (5) @(negedge clk);
      check("sb_final_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/flit_sink_monitor.md
FLIT_SINK_MONITOR -- requirements
Module: flit_sink_monitor

Interface
REQ-001 Parameter FLIT_W, default 54: flit width in bits.
REQ-002 Parameter PAYLOAD, default 20: expected flits per packet.
REQ-003 Parameter MAX_LEN, default 255: packet length cap, range 1..255.
REQ-004 Port clk, input, 1: single clock; all logic SHALL act on its rising edge.
REQ-005 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 Port flit_valid, input, 1: a flit is present on flit_data.
REQ-007 Port flit_data, input, FLIT_W: flit payload.
REQ-008 Port flit_ready, output, 1: sink can accept; a flit is accepted when flit_valid and flit_ready are both high.
REQ-009 Port pkt_done, output, 1: one-cycle pulse; the packet report is valid.
REQ-010 Port pkt_len, output, 8: accepted flits in the reported packet.
REQ-011 Port pkt_toggles, output, 16: bit toggles summed over the reported packet.
REQ-012 Port len_err, output, 1: pkt_len differed from PAYLOAD; valid with pkt_done.
REQ-013 Port pkt_count, output, 16: packets reported since reset; wraps at 2^16.
REQ-014 Port total_toggles, output, 32: toggles accumulated since reset; saturates at 32'hFFFFFFFF.

Function
REQ-015 The block SHALL implement a state machine with three states: IDLE, RECV and REPORT.
REQ-016 IDLE: flit_ready=1; an accepted flit SHALL move the state to RECV.
REQ-017 RECV: flit_ready=1; a cycle with flit_valid low SHALL move the state to REPORT.
REQ-018 RECV: an accepted flit that brings the length to MAX_LEN SHALL move the state to REPORT (truncation).
REQ-019 REPORT: flit_ready=0 and pkt_done=1 for exactly one cycle, then IDLE; a flit offered during REPORT SHALL NOT be accepted and is held by the sender.
REQ-020 Per accepted flit, the toggle count SHALL equal popcount(flit_data XOR prev_flit), 0..FLIT_W; prev_flit SHALL then load flit_data.
REQ-021 prev_flit SHALL persist across packet boundaries and SHALL be cleared only by reset.
REQ-022 The length and toggle accumulators SHALL clear on the first accepted flit of a packet.
REQ-023 pkt_toggles SHALL be 16 bits wide, since the maximum is 54*255=13770.
REQ-024 pkt_len, pkt_toggles and len_err SHALL be registered, SHALL update on entry to REPORT, and SHALL hold until the next REPORT.
REQ-025 pkt_done SHALL assert in the cycle after the terminating low-valid cycle, or after the MAX_LEN-th flit.
REQ-026 len_err SHALL be (pkt_len != PAYLOAD); truncated packets SHALL therefore flag len_err whenever MAX_LEN != PAYLOAD.
REQ-027 pkt_count SHALL increment and total_toggles SHALL add the packet sum in the REPORT cycle.
REQ-028 Accepted flits after a truncation SHALL form a new packet starting in IDLE.

Reset
REQ-029 While rst_n=0 at a clk edge: state IDLE, flit_ready=1, pkt_done=0, pkt_len=0, pkt_toggles=0, len_err=0, pkt_count=0, total_toggles=0, prev_flit=0.
REQ-030 Reset mid-packet SHALL discard the partial packet with no pkt_done and no counter update.
REQ-031 flit_valid asserted in the reset cycle SHALL NOT be accepted.

Configuration
REQ-032 Macro FLIT_HALF_TOGGLE_EN defined: add 16-bit output ports pkt_toggles_lo and pkt_toggles_hi.
REQ-033 pkt_toggles_lo SHALL count toggles on bits [FLIT_W/2-1:0] and pkt_toggles_hi on bits [FLIT_W-1:FLIT_W/2].
REQ-034 pkt_toggles_lo and pkt_toggles_hi SHALL have the same reset, update and hold rules as pkt_toggles, with pkt_toggles_lo + pkt_toggles_hi = pkt_toggles.
REQ-035 Macro FLIT_HALF_TOGGLE_EN undefined: the two ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 Reset; 3 flits 0, 54'h3FFFFFFFFFFFFF, 0; then valid low -> pkt_done one cycle later, pkt_len=3, pkt_toggles=108, len_err=1, pkt_count=1.
REQ-037 Reset; 20 flits alternating 54'h1 and 0; 7 idle cycles -> pkt_len=20, pkt_toggles=20, len_err=0, total_toggles=20.
REQ-038 flit_valid held high through REPORT -> flit_ready=0 for that cycle, no flit lost, next packet pkt_len counts the held flit once.
REQ-039 flit_valid high for 300 consecutive cycles -> first report pkt_len=255, len_err=1; second report pkt_len=45 (300 minus 255 accepted).
REQ-040 rst_n low at flit 10 of a packet, then a fresh 20-flit packet -> one report only, pkt_count=1, prev_flit restarted from 0.
REQ-041 With FLIT_HALF_TOGGLE_EN, flit 0 then 54'h3FFFFFFFFFFFFF (FLIT_W=54) -> pkt_toggles_lo=27, pkt_toggles_hi=27.
